vga_timing_gen: RTL and testbench

//   Generates 640x480@60Hz VGA raster timing from the 50 MHz system clock. Drives DrawX/DrawY into
//   the background mapper and sprite mappers, and drives hs/vs/blank_n to the VGA connector.

---
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Free-running VGA raster timing generator (640x480@60Hz by default) clocked
//   from the 50 MHz system clock. A clock divider produces a one-clock pixel
//   enable, and all raster state advances only on that enable. DrawX/DrawY feed
//   the background and sprite mappers undelayed. hs/vs/blank_n are delayed by
//   SYNC_DELAY pixel ticks so they line up with the mapper's ROM read latency.
//
// Ports
//   clock        in   system clock
//   reset_n      in   asynchronous reset, active low
//   pixel_ce     out  one-clock pulse every CLK_DIV clocks
//   DrawX        out  horizontal counter, 0..H_TOTAL-1
//   DrawY        out  vertical counter, 0..V_TOTAL-1
//   hs           out  horizontal sync, active low, delayed SYNC_DELAY ticks
//   vs           out  vertical sync, active low, delayed SYNC_DELAY ticks
//   blank_n      out  high in the visible region, delayed SYNC_DELAY ticks
//   line_start   out  one-clock strobe, DrawX has just become 0
//   frame_start  out  one-clock strobe, DrawX/DrawY have just become (0,0)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       pixel_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank_n,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Idle value of a sync/blank triple {hs, vs, blank_n}: syncs inactive, blanked.
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  logic [DIV_W-1:0] div_cnt;
  logic             x_wrap;
  logic             y_wrap;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic [2:0]       sync_next;

  // Stage 0 holds the decode of the counter values being loaded on the same
  // pixel_ce, i.e. a zero-delay registered copy; stages 1..SYNC_DELAY add the
  // pixel-tick delay on top of that.
  logic [2:0]       sync_pipe [0:SYNC_DELAY];

  // Pixel clock enable: registered so it is a clean single-clock pulse that
  // lands on the clock after the divider reaches its last count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      pixel_ce <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      pixel_ce <= (div_cnt == DIV_LAST);
    end
  end

  // Next raster position and the sync/blank decode of that position. Decoding
  // the next position lets the whole delay pipe load in step with the counters.
  always_comb begin
    x_wrap    = (DrawX == H_LAST);
    y_wrap    = (DrawY == V_LAST);
    x_next    = x_wrap ? 10'd0 : DrawX + 10'd1;
    y_next    = DrawY;
    if (x_wrap) begin
      y_next = y_wrap ? 10'd0 : DrawY + 10'd1;
    end
    sync_next = {
      ~((x_next >= HS_FIRST) && (x_next <= HS_LAST)),
      ~((y_next >= VS_FIRST) && (y_next <= VS_LAST)),
      (x_next < H_VIS_END) && (y_next < V_VIS_END)
    };
  end

  // Raster counters and the start-of-line/frame strobes. The strobes are set on
  // the same edge that wraps the counters, so they are high exactly while the
  // new (0, y) position is first presented; a reset never produces them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pixel_ce) begin
        DrawX       <= x_next;
        DrawY       <= y_next;
        line_start  <= x_wrap;
        frame_start <= x_wrap && y_wrap;
      end
    end
  end

  // Sync/blank delay pipe. Reset flushes every stage to the idle triple, so
  // blank_n stays low until the restarted raster has propagated through.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= SYNC_DELAY; i++) begin
        sync_pipe[i] <= SYNC_IDLE;
      end
    end else if (pixel_ce) begin
      sync_pipe[0] <= sync_next;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        sync_pipe[i] <= sync_pipe[i-1];
      end
    end
  end

  assign hs      = sync_pipe[SYNC_DELAY][2];
  assign vs      = sync_pipe[SYNC_DELAY][1];
  assign blank_n = sync_pipe[SYNC_DELAY][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Three instances share clock and reset:
//   the default 640x480 timing, a SYNC_DELAY=0 copy, and a shrunken raster
//   (25 x 10 pixels, CLK_DIV=2) so whole frames fit in a short run.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic       clock;
  logic       reset_n;

  logic       pixel_ce, hs, vs, blank_n, line_start, frame_start;
  logic [9:0] DrawX, DrawY;

  logic       z_pixel_ce, z_hs, z_vs, z_blank_n, z_line_start, z_frame_start;
  logic [9:0] z_DrawX, z_DrawY;

  logic       s_pixel_ce, s_hs, s_vs, s_blank_n, s_line_start, s_frame_start;
  logic [9:0] s_DrawX, s_DrawY;

  int checks = 0;
  int errors = 0;

  vga_timing_gen dut (
    .clock(clock), .reset_n(reset_n), .pixel_ce(pixel_ce),
    .DrawX(DrawX), .DrawY(DrawY), .hs(hs), .vs(vs), .blank_n(blank_n),
    .line_start(line_start), .frame_start(frame_start)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) dut_zero (
    .clock(clock), .reset_n(reset_n), .pixel_ce(z_pixel_ce),
    .DrawX(z_DrawX), .DrawY(z_DrawY), .hs(z_hs), .vs(z_vs), .blank_n(z_blank_n),
    .line_start(z_line_start), .frame_start(z_frame_start)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(2)
  ) dut_small (
    .clock(clock), .reset_n(reset_n), .pixel_ce(s_pixel_ce),
    .DrawX(s_DrawX), .DrawY(s_DrawY), .hs(s_hs), .vs(s_vs), .blank_n(s_blank_n),
    .line_start(s_line_start), .frame_start(s_frame_start)
  );

  // 50 MHz system clock.
  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic applyStimulus(input logic rst_level);
    reset_n = rst_level;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and sample on the following falling edge.
  task automatic stepClocks(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic waitMainX(input logic [9:0] target, input int budget, output logic ok);
    int n;
    n = 0;
    while (DrawX !== target && n < budget) begin
      stepClocks(1);
      n++;
    end
    ok = (DrawX === target);
  endtask

  initial begin
    int   n;
    logic ok;

    // Reset held: every output at its reset value.
    applyStimulus(1'b0);
    stepClocks(5);
    checkOutput("rst_DrawX", DrawX, 0);
    checkOutput("rst_DrawY", DrawY, 0);
    checkOutput("rst_hs", hs, 1);
    checkOutput("rst_vs", vs, 1);
    checkOutput("rst_blank_n", blank_n, 0);
    checkOutput("rst_pixel_ce", pixel_ce, 0);
    checkOutput("rst_line_start", line_start, 0);
    checkOutput("rst_frame_start", frame_start, 0);

    // Release on a falling edge; pixel_ce appears on the 2nd clock, DrawX moves on the 3rd.
    applyStimulus(1'b1);
    stepClocks(1);
    checkOutput("ce_clk1", pixel_ce, 0);
    stepClocks(1);
    checkOutput("ce_clk2", pixel_ce, 1);
    checkOutput("x_clk2", DrawX, 0);
    stepClocks(1);
    checkOutput("ce_clk3", pixel_ce, 0);
    checkOutput("x_clk3", DrawX, 1);
    checkOutput("no_line_start_from_reset", line_start, 0);
    checkOutput("no_frame_start_from_reset", frame_start, 0);
    stepClocks(1);
    checkOutput("ce_clk4", pixel_ce, 1);
    stepClocks(1);
    checkOutput("x_clk5", DrawX, 2);

    // Blank edge: zero-delay copy drops with DrawX=640, default one 2 ticks later.
    waitMainX(10'd639, 3000, ok);
    checkOutput("reach_x639", ok, 1);
    checkOutput("zero_blank_at_639", z_blank_n, 1);
    stepClocks(2);
    checkOutput("x_640", DrawX, 640);
    checkOutput("zero_blank_at_640", z_blank_n, 0);
    checkOutput("blank_at_640", blank_n, 1);
    checkOutput("y_line0", DrawY, 0);
    n = 0;
    do begin stepClocks(1); n++; end while (blank_n !== 1'b0 && n < 100);
    checkOutput("blank_fall_clocks", n, 4);

    // Hsync: low 2 ticks after DrawX=656, for 96 ticks.
    waitMainX(10'd656, 100, ok);
    checkOutput("reach_x656", ok, 1);
    checkOutput("hs_at_656", hs, 1);
    n = 0;
    do begin stepClocks(1); n++; end while (hs !== 1'b0 && n < 100);
    checkOutput("hs_fall_clocks", n, 4);
    n = 0;
    do begin stepClocks(1); n++; end while (hs !== 1'b1 && n < 400);
    checkOutput("hs_low_clocks", n, 192);

    // Line wrap: DrawX 799->0, DrawY 0->1, line_start only.
    n = 0;
    while (line_start !== 1'b1 && n < 400) begin stepClocks(1); n++; end
    checkOutput("line_start_seen", line_start, 1);
    checkOutput("ls_DrawX", DrawX, 0);
    checkOutput("ls_DrawY", DrawY, 1);
    checkOutput("ls_no_frame_start", frame_start, 0);
    stepClocks(1);
    checkOutput("line_start_one_clock", line_start, 0);

    // Small raster: frame wrap 24,9 -> 0,0 on one pixel_ce with both strobes.
    n = 0;
    while (!(s_DrawX === 10'd24 && s_DrawY === 10'd9) && n < 1200) begin stepClocks(1); n++; end
    checkOutput("reach_small_corner", (s_DrawX === 10'd24 && s_DrawY === 10'd9), 1);
    stepClocks(2);
    checkOutput("small_wrap_x", s_DrawX, 0);
    checkOutput("small_wrap_y", s_DrawY, 0);
    checkOutput("small_frame_start", s_frame_start, 1);
    checkOutput("small_line_start", s_line_start, 1);
    n = 0;
    do begin stepClocks(1); n++; end while (s_frame_start !== 1'b1 && n < 1000);
    checkOutput("small_frame_period", n, 500);

    // Small raster vsync: 2 lines of 25 ticks at 2 clocks each.
    n = 0;
    while (s_vs !== 1'b0 && n < 1000) begin stepClocks(1); n++; end
    checkOutput("small_vs_seen", s_vs, 0);
    n = 0;
    do begin stepClocks(1); n++; end while (s_vs !== 1'b1 && n < 1000);
    checkOutput("small_vs_low_clocks", n, 100);

    // Mid-line asynchronous reset, then restart with a flushed pipe.
    waitMainX(10'd300, 2000, ok);
    checkOutput("reach_x300", ok, 1);
    checkOutput("pre_reset_blank", blank_n, 1);
    #3;
    applyStimulus(1'b0);
    #1;
    checkOutput("async_DrawX", DrawX, 0);
    checkOutput("async_DrawY", DrawY, 0);
    checkOutput("async_blank_n", blank_n, 0);
    checkOutput("async_hs", hs, 1);
    checkOutput("async_vs", vs, 1);
    checkOutput("async_pixel_ce", pixel_ce, 0);
    stepClocks(2);
    applyStimulus(1'b1);
    n = 0;
    do begin stepClocks(1); n++; end while (blank_n !== 1'b1 && n < 100);
    checkOutput("restart_blank_rise_clocks", n, 7);
    checkOutput("restart_DrawX", DrawX, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
